capture_buffer_mc: RTL and testbench
====================================

CAPTURE_BUFFER_MC -- requirements
Module: capture_buffer_mc

Interface
REQ-001 SHALL have parameter BUFFER_LENGTH, default 16: samples per channel (power of two not required).
REQ-002 SHALL have parameter INDEX_BITS, default 4: address width, at least ceil(log2(BUFFER_LENGTH)).
REQ-003 SHALL have parameters I_BITS and Q_BITS, default 12 each: signed I and Q widths.
REQ-004 SHALL have parameter NUM_CH, default 2: channel count. SHALL have parameter CH_BITS, default 1: channel-select width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have these ports, as name / direction / width / meaning:
- clk / in / 1 / rising-edge clock.
- rst_n / in / 1 / asynchronous active-low reset.
- arm / in / 1 / pulse that starts a capture.
- trigger / in / 1 / trigger qualifier, sampled only with s_valid.
- pre_trig / in / INDEX_BITS / pre-trigger depth, latched on arm.
- s_valid / in / 1 / input sample valid.
- s_data / in / NUM_CH*(I_BITS+Q_BITS) / channel k at slice k; I in the upper bits, Q in the lower bits.
- capturing / out / 1 / high in PRE, WAIT_TRIG and POST.
- done / out / 1 / high in DONE.
- trig_index / out / INDEX_BITS / physical address of the trigger sample.
- m_axi_raddr / in / INDEX_BITS / logical read address; 0 is the oldest sample.
- m_axi_rch / in / CH_BITS / read channel.
- m_axi_rvalid / in / 1 / read request.
- s_axi_rready / out / 1 / read request accepted.
- s_axi_rvalid / out / 1 / read data valid.
- m_axi_rready / in / 1 / read data consumed.
- i / out / I_BITS signed / read I.
- q / out / Q_BITS signed / read Q.
- s_axi_rresp / out / 1 / 1 = error.

Function
REQ-007 SHALL implement the states IDLE, PRE, WAIT_TRIG, POST and DONE.
REQ-008 On arm in any state, SHALL latch pre_trig, clamped to BUFFER_LENGTH-1, and SHALL clear wptr.
- Next state is PRE, or WAIT_TRIG if the latched pre_trig is 0.
- An arm during a capture restarts the capture.
REQ-009 Each accepted s_valid in PRE, WAIT_TRIG or POST SHALL write all NUM_CH channels at wptr.
- wptr then increments and wraps from BUFFER_LENGTH-1 to 0.
REQ-010 PRE SHALL count writes and move to WAIT_TRIG after exactly pre_trig writes; triggers in PRE are ignored.
REQ-011 In WAIT_TRIG, s_valid together with trigger SHALL write that sample and set trig_index to wptr.
- Post count loads BUFFER_LENGTH-1-pre_trig; next state is POST, or DONE if the count is 0.
REQ-012 POST SHALL decrement the post count per write and move to DONE on the write that reaches 0.
- Triggers in POST and DONE are ignored.
REQ-013 Physical read address SHALL be (trig_index - pre_trig + m_axi_raddr) mod BUFFER_LENGTH, using the latched pre_trig.
REQ-014 A request SHALL be accepted when m_axi_rvalid is high and no read response is pending.
- s_axi_rready pulses for 1 cycle on acceptance.
- s_axi_rvalid, i and q follow 1 cycle later and hold until m_axi_rready is high.
REQ-015 A request in a state other than DONE or IDLE SHALL return rresp=1 with i=q=0.
- A request with m_axi_raddr >= BUFFER_LENGTH or m_axi_rch >= NUM_CH SHALL also return rresp=1 with i=q=0.
REQ-016 A write and a read to the same physical location in the same cycle SHALL return the old data.
REQ-017 i and q SHALL be taken from the selected channel's slice with sign preserved and no truncation.

Reset
REQ-018 While rst_n is low, SHALL force state IDLE, wptr=0, counters=0 and trig_index=0.
- Outputs during reset: capturing=0, done=0, s_axi_rready=0, s_axi_rvalid=0, s_axi_rresp=0, i=0, q=0.
REQ-019 Reset mid-capture SHALL abort the capture; memory contents are undefined after reset.

Structure
REQ-020 Package caf_capture_pkg SHALL hold the state enumeration and the RESP_OKAY/RESP_ERR constants.
REQ-021 Storage SHALL be a sub-module capture_ram: one write port, one registered read port, width NUM_CH*(I_BITS+Q_BITS), depth BUFFER_LENGTH.

Verification (BUFFER_LENGTH=16, NUM_CH=2)
REQ-022 arm with pre_trig=4; ramp samples 0..; trigger on sample 10 -> trig_index=10, done after sample 21; logical reads 0..15 return samples 6..21.
REQ-023 pre_trig=0; trigger on the first sample -> logical address 0 holds the trigger sample; done after 16 writes.
REQ-024 pre_trig=15 with wptr wrapping; trigger at wptr=3 -> DONE the next cycle; logical 15 holds the trigger sample and logical 0 is at physical 4.
REQ-025 Read during POST, raddr=16 or rch=2 -> rresp=1, i=q=0; read with m_axi_rready low for 3 cycles -> data held, no new acceptance.
REQ-026 rst_n low during POST, then re-arm -> all outputs at reset values; a new capture completes correctly.
REQ-027 arm during WAIT_TRIG -> wptr restarts at 0 and the earlier capture is discarded.

Source files
------------

// File: rtl/caf_capture_pkg.sv
// Shared types and constants for the multi-channel capture buffer.
package caf_capture_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StWaitTrig,
        StPost,
        StDone
    } cap_state_e;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/capture_buffer_mc_if.sv
// Read-back bus of the capture buffer: request/accept handshake plus data/response return.
interface capture_buffer_mc_if #(
    parameter int INDEX_BITS = 4,
    parameter int CH_BITS    = 1,
    parameter int I_BITS     = 12,
    parameter int Q_BITS     = 12
) ();

    logic [INDEX_BITS-1:0]    m_axi_raddr;
    logic [CH_BITS-1:0]       m_axi_rch;
    logic                     m_axi_rvalid;
    logic                     s_axi_rready;
    logic                     s_axi_rvalid;
    logic                     m_axi_rready;
    logic signed [I_BITS-1:0] i;
    logic signed [Q_BITS-1:0] q;
    logic                     s_axi_rresp;

    modport master (
        output m_axi_raddr,
        output m_axi_rch,
        output m_axi_rvalid,
        output m_axi_rready,
        input  s_axi_rready,
        input  s_axi_rvalid,
        input  i,
        input  q,
        input  s_axi_rresp
    );

    modport slave (
        input  m_axi_raddr,
        input  m_axi_rch,
        input  m_axi_rvalid,
        input  m_axi_rready,
        output s_axi_rready,
        output s_axi_rvalid,
        output i,
        output q,
        output s_axi_rresp
    );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port (read-before-write).
module capture_ram #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 48
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [DATA_BITS-1:0] i_wr_data,
    input  logic                 i_rd_en,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [DATA_BITS-1:0] o_rd_data
);

    localparam int DEPTH_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_BITS-1:0]  r_mem [DEPTH];
    logic [DATA_BITS-1:0]  r_rd_data;
    logic [DEPTH_BITS-1:0] w_wr_idx;
    logic [DEPTH_BITS-1:0] w_rd_idx;

    // Callers keep addresses below DEPTH, so only the low bits carry information.
    assign w_wr_idx = DEPTH_BITS'(i_wr_addr);
    assign w_rd_idx = DEPTH_BITS'(i_rd_addr);

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/capture_buffer_mc.sv
// Multi-channel I/Q pre/post-trigger capture buffer with a handshaked read-back port.
module capture_buffer_mc
    import caf_capture_pkg::*;
#(
    parameter int BUFFER_LENGTH = 16,
    parameter int INDEX_BITS    = 4,
    parameter int I_BITS        = 12,
    parameter int Q_BITS        = 12,
    parameter int NUM_CH        = 2,
    parameter int CH_BITS       = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                arm,
    input  logic                                trigger,
    input  logic [INDEX_BITS-1:0]               pre_trig,
    input  logic                                s_valid,
    input  logic [NUM_CH*(I_BITS+Q_BITS)-1:0]   s_data,
    output logic                                capturing,
    output logic                                done,
    output logic [INDEX_BITS-1:0]               trig_index,
    capture_buffer_mc_if.slave                  rd
);

    localparam int SLICE_BITS = I_BITS + Q_BITS;
    localparam int DATA_BITS  = NUM_CH * SLICE_BITS;
    localparam int EXT_BITS   = INDEX_BITS + 1;

    localparam logic [INDEX_BITS-1:0] MAX_IDX = INDEX_BITS'(BUFFER_LENGTH - 1);
    localparam logic [EXT_BITS-1:0]   LEN_EXT = EXT_BITS'(BUFFER_LENGTH);
    localparam logic [CH_BITS:0]      NCH_EXT = (CH_BITS + 1)'(NUM_CH);

    cap_state_e r_state, w_state_nxt;

    logic [INDEX_BITS-1:0] r_wptr, w_wptr_nxt;
    logic [INDEX_BITS-1:0] r_cnt, w_cnt_nxt;
    logic [INDEX_BITS-1:0] r_pre, w_pre_nxt;
    logic [INDEX_BITS-1:0] r_trig_index, w_trig_nxt;

    logic [INDEX_BITS-1:0] w_pre_clamped;
    logic [INDEX_BITS-1:0] w_wptr_inc;
    logic [INDEX_BITS-1:0] w_post_len;
    logic                  w_in_capture;
    logic                  w_wr_en;

    logic                  r_rready;
    logic                  r_rvalid;
    logic                  r_rresp;
    logic                  r_rd_err;
    logic [CH_BITS-1:0]    r_rd_ch;
    logic signed [I_BITS-1:0] r_i;
    logic signed [Q_BITS-1:0] r_q;

    logic                  w_accept;
    logic                  w_req_err;
    logic [EXT_BITS-1:0]   w_base;
    logic [EXT_BITS-1:0]   w_sum;
    logic [INDEX_BITS-1:0] w_rd_addr;
    logic [DATA_BITS-1:0]  w_rd_data;
    logic [SLICE_BITS-1:0] w_slice;
    logic signed [I_BITS-1:0] w_slice_i;
    logic signed [Q_BITS-1:0] w_slice_q;

    assign w_pre_clamped = (pre_trig > MAX_IDX) ? MAX_IDX : pre_trig;
    assign w_in_capture  = (r_state == StPre) || (r_state == StWaitTrig) || (r_state == StPost);
    // A restarting arm wins over a sample arriving in the same cycle.
    assign w_wr_en       = s_valid && !arm && w_in_capture;
    assign w_wptr_inc    = (r_wptr == MAX_IDX) ? '0 : r_wptr + 1'b1;
    assign w_post_len    = MAX_IDX - r_pre;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_wptr       <= '0;
            r_cnt        <= '0;
            r_pre        <= '0;
            r_trig_index <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wptr       <= w_wptr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pre        <= w_pre_nxt;
            r_trig_index <= w_trig_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_cnt_nxt   = r_cnt;
        w_pre_nxt   = r_pre;
        w_trig_nxt  = r_trig_index;
        if (arm) begin
            w_pre_nxt   = w_pre_clamped;
            w_wptr_nxt  = '0;
            w_cnt_nxt   = w_pre_clamped;
            w_state_nxt = (w_pre_clamped == '0) ? StWaitTrig : StPre;
        end else if (w_wr_en) begin
            w_wptr_nxt = w_wptr_inc;
            case (r_state)
                StPre: begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == INDEX_BITS'(1)) begin
                        w_state_nxt = StWaitTrig;
                    end
                end
                StWaitTrig: begin
                    if (trigger) begin
                        w_trig_nxt  = r_wptr;
                        w_cnt_nxt   = w_post_len;
                        w_state_nxt = (w_post_len == '0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == INDEX_BITS'(1)) begin
                        w_state_nxt = StDone;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        capturing = 1'b0;
        done      = 1'b0;
        case (r_state)
            StPre, StWaitTrig, StPost: capturing = 1'b1;
            StDone:                    done      = 1'b1;
            default: ;
        endcase
    end

    assign trig_index = r_trig_index;

    // Logical address 0 is the oldest kept sample, pre_trig entries before the trigger.
    always_comb begin
        w_base = ({1'b0, r_trig_index} >= {1'b0, r_pre})
               ? {1'b0, r_trig_index} - {1'b0, r_pre}
               : {1'b0, r_trig_index} + LEN_EXT - {1'b0, r_pre};
        w_sum  = w_base + {1'b0, rd.m_axi_raddr};
    end

    assign w_req_err = !((r_state == StIdle) || (r_state == StDone))
                     || ({1'b0, rd.m_axi_raddr} >= LEN_EXT)
                     || ({1'b0, rd.m_axi_rch} >= NCH_EXT);
    assign w_rd_addr = w_req_err ? '0 : INDEX_BITS'((w_sum >= LEN_EXT) ? w_sum - LEN_EXT : w_sum);
    assign w_accept  = rd.m_axi_rvalid && !r_rready && !r_rvalid;

    capture_ram #(
        .DEPTH     (BUFFER_LENGTH),
        .ADDR_BITS (INDEX_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wptr),
        .i_wr_data (s_data),
        .i_rd_en   (w_accept),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_slice = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_rd_ch == CH_BITS'(k)) begin
                w_slice = w_rd_data[k*SLICE_BITS +: SLICE_BITS];
            end
        end
    end

    assign w_slice_i = w_slice[SLICE_BITS-1 -: I_BITS];
    assign w_slice_q = w_slice[Q_BITS-1:0];

    // Accept pulse, then data one cycle later held until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rready <= 1'b0;
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rd_err <= 1'b0;
            r_rd_ch  <= '0;
            r_i      <= '0;
            r_q      <= '0;
        end else begin
            r_rready <= w_accept;
            if (w_accept) begin
                r_rd_err <= w_req_err;
                r_rd_ch  <= rd.m_axi_rch;
            end
            if (r_rready) begin
                r_rvalid <= 1'b1;
                r_rresp  <= r_rd_err ? RESP_ERR : RESP_OKAY;
                r_i      <= r_rd_err ? '0 : w_slice_i;
                r_q      <= r_rd_err ? '0 : w_slice_q;
            end else if (r_rvalid && rd.m_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign rd.s_axi_rready = r_rready;
    assign rd.s_axi_rvalid = r_rvalid;
    assign rd.s_axi_rresp  = r_rresp;
    assign rd.i            = r_i;
    assign rd.q            = r_q;

endmodule

// File: tb/tb_capture_buffer_mc.sv
// Randomized bench for capture_buffer_mc against a sample-history reference model.
module tb_capture_buffer_mc;

    localparam int L   = 16;
    localparam int IB  = 5;
    localparam int IW  = 12;
    localparam int QW  = 12;
    localparam int NCH = 2;
    localparam int CHB = 2;
    localparam int SW  = IW + QW;
    localparam int DW  = NCH * SW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic [IB-1:0] pre_trig = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          capturing;
    logic          done;
    logic [IB-1:0] trig_index;

    capture_buffer_mc_if #(
        .INDEX_BITS (IB),
        .CH_BITS    (CHB),
        .I_BITS     (IW),
        .Q_BITS     (QW)
    ) rd_if ();

    capture_buffer_mc #(
        .BUFFER_LENGTH (L),
        .INDEX_BITS    (IB),
        .I_BITS        (IW),
        .Q_BITS        (QW),
        .NUM_CH        (NCH),
        .CH_BITS       (CHB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .trigger    (trigger),
        .pre_trig   (pre_trig),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .capturing  (capturing),
        .done       (done),
        .trig_index (trig_index),
        .rd         (rd_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: every sample written since the last arm, in order, plus the trigger's sequence index.
    logic [DW-1:0] hist [$];
    int m_pre  = 0;
    int m_trig = -1;
    bit m_armed = 1'b0;
    bit m_done  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ramp_word(input int n);
        logic [11:0] a;
        a = 12'(n);
        return {a + 12'h100, ~a, a, 12'h000 - a};
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom, $urandom});
    endfunction

    task automatic model_clear();
        hist.delete();
        m_trig = -1;
        m_done = 1'b0;
    endtask

    task automatic arm_cap(input int p);
        arm      = 1'b1;
        pre_trig = IB'(p);
        s_valid  = 1'b0;
        trigger  = 1'b0;
        @(posedge clk);
        model_clear();
        m_pre   = (p > L - 1) ? L - 1 : p;
        m_armed = 1'b1;
        #1;
        arm = 1'b0;
        check_eq("arm_capturing", 32'(capturing), 32'd1);
        check_eq("arm_done", 32'(done), 32'd0);
    endtask

    task automatic step(input logic v, input logic t, input logic [DW-1:0] d);
        int idx;
        s_valid = v;
        trigger = t;
        s_data  = d;
        @(posedge clk);
        if (v && m_armed && !m_done) begin
            idx = hist.size();
            hist.push_back(d);
            if (m_trig < 0 && t && idx >= m_pre) m_trig = idx;
            if (m_trig >= 0 && hist.size() == m_trig + L - m_pre) m_done = 1'b1;
        end
        #1;
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("capturing", 32'(capturing), 32'(m_armed && !m_done));
        if (m_trig >= 0) check_eq("trig_index", 32'(trig_index), 32'(m_trig % L));
    endtask

    task automatic feed_until_done(input int trig_idx, input bit gaps, input bit ramp);
        int  cyc;
        int  idx;
        logic v;
        logic t;
        cyc = 0;
        while (!m_done && cyc < 500) begin
            idx = hist.size();
            v = gaps ? ($urandom_range(3) != 0) : 1'b1;
            t = (trig_idx < 0) ? ($urandom_range(7) == 0) : (idx == trig_idx || idx == 2);
            step(v, t, ramp ? ramp_word(idx) : rand_word());
            cyc++;
        end
        s_valid = 1'b0;
        trigger = 1'b0;
        check_eq("capture_finished", 32'(m_done), 32'd1);
    endtask

    task automatic feed_n(input int n, input int trig_idx);
        for (int c = 0; c < n; c++) begin
            step(1'b1, hist.size() == trig_idx, rand_word());
        end
        s_valid = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic post_done_steps();
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, rand_word());
        s_valid = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic rd_req(input int addr, input int ch, input int hold,
                          output logic [IW-1:0] oi, output logic [QW-1:0] oq, output logic oresp);
        bit got;
        rd_if.m_axi_raddr  = IB'(addr);
        rd_if.m_axi_rch    = CHB'(ch);
        rd_if.m_axi_rvalid = 1'b1;
        rd_if.m_axi_rready = 1'b0;
        got = 1'b0;
        oi = '0;
        oq = '0;
        oresp = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk);
            #1;
            got = rd_if.s_axi_rready;
        end
        rd_if.m_axi_rvalid = 1'b0;
        if (!got) begin
            check_eq("rd_accept_timeout", 32'd0, 32'd1);
            return;
        end
        check_eq("rvalid_lag", 32'(rd_if.s_axi_rvalid), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rvalid", 32'(rd_if.s_axi_rvalid), 32'd1);
        oi = rd_if.i;
        oq = rd_if.q;
        oresp = rd_if.s_axi_rresp;
        for (int h = 0; h < hold; h++) begin
            rd_if.m_axi_rvalid = 1'b1;
            @(posedge clk);
            #1;
            check_eq("no_new_accept", 32'(rd_if.s_axi_rready), 32'd0);
            check_eq("rvalid_hold", 32'(rd_if.s_axi_rvalid), 32'd1);
            check_eq("data_hold", 32'({rd_if.i, rd_if.q}), 32'({oi, oq}));
        end
        rd_if.m_axi_rvalid = 1'b0;
        rd_if.m_axi_rready = 1'b1;
        @(posedge clk);
        #1;
        rd_if.m_axi_rready = 1'b0;
        check_eq("rvalid_clear", 32'(rd_if.s_axi_rvalid), 32'd0);
    endtask

    task automatic read_check(input int addr, input int ch, input int hold);
        logic [IW-1:0] gi;
        logic [QW-1:0] gq;
        logic          gr;
        logic [DW-1:0] w;
        bit            exp_err;
        logic [IW-1:0] ei;
        logic [QW-1:0] eq;
        exp_err = (m_armed && !m_done) || addr >= L || ch >= NCH;
        ei = '0;
        eq = '0;
        if (!exp_err) begin
            w  = hist[m_trig - m_pre + addr] >> (ch * SW);
            ei = w[SW-1:QW];
            eq = w[QW-1:0];
        end
        rd_req(addr, ch, hold, gi, gq, gr);
        check_eq($sformatf("rd_resp[%0d,%0d]", addr, ch), 32'(gr), 32'(exp_err));
        check_eq($sformatf("rd_i[%0d,%0d]", addr, ch), 32'(gi), 32'(ei));
        check_eq($sformatf("rd_q[%0d,%0d]", addr, ch), 32'(gq), 32'(eq));
    endtask

    task automatic read_all();
        for (int k = 0; k < L; k++) begin
            for (int ch = 0; ch < NCH; ch++) read_check(k, ch, $urandom_range(0, 3));
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_capturing", 32'(capturing), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_trig_index", 32'(trig_index), 32'd0);
        check_eq("rst_rready", 32'(rd_if.s_axi_rready), 32'd0);
        check_eq("rst_rvalid", 32'(rd_if.s_axi_rvalid), 32'd0);
        check_eq("rst_rresp", 32'(rd_if.s_axi_rresp), 32'd0);
        check_eq("rst_i", 32'({rd_if.i}), 32'd0);
        check_eq("rst_q", 32'({rd_if.q}), 32'd0);
    endtask

    initial begin
        rd_if.m_axi_raddr  = '0;
        rd_if.m_axi_rch    = '0;
        rd_if.m_axi_rvalid = 1'b0;
        rd_if.m_axi_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp, pre=4, trigger on sample 10 (sample 2 trigger falls in PRE).
        arm_cap(4);
        feed_until_done(10, 1'b0, 1'b1);
        check_eq("ramp_trig_index", 32'(trig_index), 32'd10);
        post_done_steps();
        read_all();
        read_check(16, 0, 1);
        read_check(3, 2, 3);
        read_check(31, 3, 0);

        // pre=0: the trigger sample is logical 0.
        arm_cap(0);
        feed_until_done(0, 1'b1, 1'b0);
        post_done_steps();
        read_all();

        // pre clamps to 15; trigger lands on wptr=3 after wrap.
        arm_cap(20);
        feed_until_done(19, 1'b1, 1'b0);
        check_eq("wrap_trig_index", 32'(trig_index), 32'd3);
        read_all();

        // Reads while in POST are rejected.
        arm_cap(2);
        feed_n(8, 4);
        read_check(0, 0, 0);
        read_check(16, 0, 3);
        read_check(1, 2, 3);
        feed_until_done(-1, 1'b1, 1'b0);
        read_all();

        // Re-arm while waiting for the trigger discards the first capture.
        arm_cap(3);
        feed_n(9, -1);
        arm_cap(5);
        feed_until_done(-1, 1'b1, 1'b0);
        read_all();

        // Reset in POST, then a fresh capture.
        arm_cap(2);
        feed_n(7, 3);
        #2;
        rst_n = 1'b0;
        m_armed = 1'b0;
        model_clear();
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, rand_word());
        s_valid = 1'b0;
        trigger = 1'b0;
        arm_cap(6);
        feed_until_done(-1, 1'b1, 1'b0);
        read_all();

        for (int r = 0; r < 4; r++) begin
            arm_cap($urandom_range(0, 31));
            feed_until_done(-1, 1'b1, 1'b0);
            post_done_steps();
            read_all();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
